tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter ALIGN_FRAMES, default 2: consecutive good frames required before lock; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 din  input  1  serial TDM data bit; one channel slot per accepted beat.
REQ-005 din_en  input  1  beat strobe; din and fsync sampled only when high.
REQ-006 fsync  input  1  frame marker; high on the slot-0 beat only.
REQ-007 y  output  8  demultiplexed channel bits; slot k drives y[k] (slot 0 = channel a ... slot 7 = channel h).
REQ-008 y_valid  output  1  one-cycle pulse when y is updated.
REQ-009 locked  output  1  high while the state is LOCKED.
REQ-010 sync_err  output  1  one-cycle pulse on framing violation.
REQ-011 parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.

Function
REQ-012 Beats with din_en low shall change no state, counter, shadow or output; fsync is ignored on those cycles.
REQ-013 Frame length shall be FRAME_LEN beats: 8 data slots, plus 1 parity slot when parity is enabled.
REQ-014 A slot counter shall advance on each accepted beat and wrap from FRAME_LEN-1 to 0.
REQ-015 Each accepted data beat shall be stored in shadow bit [slot]; y is never written mid-frame.
REQ-016 The FSM shall have three states: HUNT, SYNC and LOCKED.
REQ-017 In HUNT, beats without fsync are discarded; a beat with fsync shall be taken as slot 0, set good_cnt=0 and enter SYNC.
REQ-018 In SYNC, completing the final slot with no framing violation shall increment good_cnt; when good_cnt reaches ALIGN_FRAMES, the FSM enters LOCKED.
REQ-019 In SYNC and LOCKED, fsync=1 on any beat other than slot 0 shall pulse sync_err, discard the partial frame, take that beat as slot 0, clear good_cnt and enter SYNC.
REQ-020 In SYNC and LOCKED, fsync=0 on an expected slot-0 beat shall pulse sync_err, discard the beat and enter HUNT.
REQ-021 A frame completed in LOCKED shall copy shadow to y and pulse y_valid in the cycle after the final-slot beat.
REQ-022 The frame whose completion causes the SYNC-to-LOCKED transition shall also be published under the same timing.
REQ-023 locked shall rise in the cycle after the final beat of the ALIGN_FRAMES-th good frame, coincident with that frame's y_valid.
REQ-024 locked shall fall in the cycle after a violating beat.
REQ-025 y shall hold its last published value across sync_err, HUNT and SYNC.
REQ-026 sync_err and y_valid shall never pulse for the same beat.

Reset
REQ-027 While rst_n is low at a clock edge: y=8'h00, y_valid=0, locked=0, sync_err=0, parity_err=0, state=HUNT, slot=0, good_cnt=0 and shadow=0.
REQ-028 Reset asserted mid-frame shall discard the partial frame; there is no carry-over into post-reset frames.

Configuration
REQ-029 With TDM_DEMUX_PARITY_EN defined, FRAME_LEN=9 and slot 8 carries even parity over slots 0-7.
REQ-030 With TDM_DEMUX_PARITY_EN defined and parity mismatching: pulse parity_err, suppress y_valid, hold y; lock state and good_cnt are unaffected.
REQ-031 Without TDM_DEMUX_PARITY_EN: FRAME_LEN=8, no parity logic is synthesised, and parity_err is tied 0.

Structure
REQ-032 Package tdm_pkg shall hold NUM_CH=8, SLOT_W=4, the FSM state typedef (HUNT/SYNC/LOCKED) and the FRAME_LEN constant.
REQ-033 A sub-module tdm_slot_counter shall implement the enable/clear/load-zero wrap counter of REQ-014.

Verification
REQ-034 Reset, then two clean frames of data 8'b0100_1110 (slot0 first: 0,1,1,1,0,0,1,0), ALIGN_FRAMES=2 -> locked=1 and y=8'h4E with y_valid on the cycle after the 16th beat.
REQ-035 While locked, stray fsync on slot 3 -> sync_err pulse, locked=0 next cycle, y holds 8'h4E, and the beat is treated as slot 0.
REQ-036 While locked, fsync=0 on slot 0 -> sync_err pulse, HUNT entered; a later fsync beat plus 2 clean frames relocks.
REQ-037 din_en toggled 1/0 each cycle during a frame -> results identical to the contiguous case; y_valid occurs only after the 8th accepted beat.
REQ-038 rst_n low on slot 5 of a locked frame -> all outputs 0 next edge; the first post-reset fsync starts a fresh SYNC.
REQ-039 With TDM_DEMUX_PARITY_EN, data 8'hA5 with wrong parity bit 1 -> parity_err pulse, no y_valid, locked stays 1; with correct parity 0 -> y=8'hA5.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants and FSM state type for the TDM demultiplexer.
// TDM_DEMUX_PARITY_EN adds a trailing even-parity slot to every frame.
package tdm_pkg;

  localparam int NUM_CH = 8;
  localparam int SLOT_W = 4;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_LEN = NUM_CH + 1;
`else
  localparam int FRAME_LEN = NUM_CH;
`endif

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Frame slot counter: advances per accepted beat, wraps at the last slot.
// load_zero treats the current beat as slot 0, so the next slot becomes 1.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              load_zero,
  output logic [SLOT_W-1:0] slot
);

  logic [SLOT_W-1:0] base;
  logic [SLOT_W-1:0] nxt;

  always_comb begin
    base = load_zero ? '0 : slot;
    nxt  = (base == LAST_SLOT) ? '0 : base + SLOT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   slot <= '0;
    else if (clr) slot <= '0;
    else if (en)  slot <= nxt;
  end

endmodule

// File: rtl/tdm_demux.sv
// Serial TDM frame aligner and 8-channel demultiplexer.
// Optional even-parity slot enabled by TDM_DEMUX_PARITY_EN.
//
// state  | meaning
// HUNT   | waiting for an fsync beat to start a frame
// SYNC   | framing seen, counting good frames towards ALIGN_FRAMES
// LOCKED | aligned; every completed frame is published to y
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int ALIGN_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_en,
  input  logic              fsync,
  output logic [NUM_CH-1:0] y,
  output logic              y_valid,
  output logic              locked,
  output logic              sync_err,
  output logic              parity_err
);

  state_t            state, state_nx;
  logic [SLOT_W-1:0] slot, eff_slot;
  logic [3:0]        good_cnt, good_cnt_nx, good_inc;
  logic [NUM_CH-1:0] shadow, shadow_nx, frame_data, y_nx;
  logic              y_valid_nx, sync_err_nx, cnt_clr, publish;

  tdm_slot_counter u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (din_en),
    .clr       (cnt_clr),
    .load_zero (fsync),
    .slot      (slot)
  );

`ifdef TDM_DEMUX_PARITY_EN
  logic parity_err_nx;
  always_ff @(posedge clk) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= parity_err_nx;
  end
`else
  assign parity_err = 1'b0;
`endif

  assign locked = (state == LOCKED);

  always_comb begin
    state_nx    = state;
    good_cnt_nx = good_cnt;
    shadow_nx   = shadow;
    y_nx        = y;
    y_valid_nx  = 1'b0;
    sync_err_nx = 1'b0;
    cnt_clr     = 1'b0;
    publish     = 1'b0;
    good_inc    = good_cnt + 4'd1;
`ifdef TDM_DEMUX_PARITY_EN
    parity_err_nx = 1'b0;
`endif
    // Any fsync beat is slot 0; frame_data is the shadow with this beat merged in.
    eff_slot   = fsync ? '0 : slot;
    frame_data = shadow;
    if (!eff_slot[SLOT_W-1]) frame_data[eff_slot[2:0]] = din;

    if (din_en) begin
      case (state)
        HUNT: begin
          if (fsync) begin
            state_nx    = SYNC;
            good_cnt_nx = '0;
            shadow_nx   = frame_data;
          end else begin
            cnt_clr = 1'b1;
          end
        end
        default: begin
          if (fsync && slot != '0) begin
            sync_err_nx = 1'b1;
            state_nx    = SYNC;
            good_cnt_nx = '0;
            shadow_nx   = frame_data;
          end else if (!fsync && slot == '0) begin
            sync_err_nx = 1'b1;
            state_nx    = HUNT;
            good_cnt_nx = '0;
            cnt_clr     = 1'b1;
          end else begin
            shadow_nx = frame_data;
            if (slot == LAST_SLOT) begin
              publish = (state == LOCKED);
              if (state == SYNC) begin
                good_cnt_nx = good_inc;
                if (good_inc == 4'(ALIGN_FRAMES)) begin
                  state_nx = LOCKED;
                  publish  = 1'b1;
                end
              end
`ifdef TDM_DEMUX_PARITY_EN
              if ((^shadow) != din) begin
                parity_err_nx = 1'b1;
                publish       = 1'b0;
              end
`endif
              if (publish) begin
                y_nx       = frame_data;
                y_valid_nx = 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HUNT;
      good_cnt <= '0;
      shadow   <= '0;
      y        <= '0;
      y_valid  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_cnt_nx;
      shadow   <= shadow_nx;
      y        <= y_nx;
      y_valid  <= y_valid_nx;
      sync_err <= sync_err_nx;
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: lock, framing errors, gapped beats, reset, parity.
module tb_tdm_demux;

  logic       clk = 1'b0;
  logic       rst_n, din, din_en, fsync;
  logic [7:0] y;
  logic       y_valid, locked, sync_err, parity_err;

  int n_chk  = 0;
  int n_fail = 0;

  tdm_demux #(.ALIGN_FRAMES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_en     (din_en),
    .fsync      (fsync),
    .y          (y),
    .y_valid    (y_valid),
    .locked     (locked),
    .sync_err   (sync_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic d, input logic f);
    @(negedge clk);
    din = d; fsync = f; din_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_en = 1'b0; fsync = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic beats(input logic [7:0] d, input int from, input int to);
    for (int i = from; i <= to; i++) beat(d[i], (i == 0));
  endtask

  task automatic par(input logic [7:0] d, input logic bad);
`ifdef TDM_DEMUX_PARITY_EN
    beat((^d) ^ bad, 1'b0);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d);
    beats(d, 0, 7);
    par(d, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; din_en = 1'b0; fsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y", y, 8'h00);
    chk("rst_y_valid", {7'd0, y_valid}, 8'd0);
    chk("rst_locked", {7'd0, locked}, 8'd0);
    chk("rst_sync_err", {7'd0, sync_err}, 8'd0);
    chk("rst_parity_err", {7'd0, parity_err}, 8'd0);
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    // two clean frames of 8'h4E lock the aligner
    send_frame(8'h4E);
    chk("f1_y_valid", {7'd0, y_valid}, 8'd0);
    chk("f1_locked", {7'd0, locked}, 8'd0);
    send_frame(8'h4E);
    chk("lock_y_valid", {7'd0, y_valid}, 8'd1);
    chk("lock_y", y, 8'h4E);
    chk("lock_locked", {7'd0, locked}, 8'd1);
    idle(1);
    chk("lock_y_valid_pulse", {7'd0, y_valid}, 8'd0);

    // stray fsync on slot 3 restarts the frame there
    beats(8'hFF, 0, 2);
    beat(1'b0, 1'b1);
    chk("stray_sync_err", {7'd0, sync_err}, 8'd1);
    chk("stray_locked", {7'd0, locked}, 8'd0);
    chk("stray_y_hold", y, 8'h4E);
    chk("stray_no_valid", {7'd0, y_valid}, 8'd0);
    beats(8'h3C, 1, 7);
    par(8'h3C, 1'b0);
    chk("stray_f1_sync_err", {7'd0, sync_err}, 8'd0);
    chk("stray_f1_y_valid", {7'd0, y_valid}, 8'd0);
    send_frame(8'h3C);
    chk("relock1_y_valid", {7'd0, y_valid}, 8'd1);
    chk("relock1_y", y, 8'h3C);
    chk("relock1_locked", {7'd0, locked}, 8'd1);

    // missing fsync on slot 0 drops to HUNT
    beat(1'b1, 1'b0);
    chk("nosync_sync_err", {7'd0, sync_err}, 8'd1);
    chk("nosync_locked", {7'd0, locked}, 8'd0);
    chk("nosync_y_hold", y, 8'h3C);
    beat(1'b1, 1'b0);
    chk("hunt_discard_sync_err", {7'd0, sync_err}, 8'd0);
    send_frame(8'h81);
    chk("hunt_f1_y_valid", {7'd0, y_valid}, 8'd0);
    chk("hunt_f1_locked", {7'd0, locked}, 8'd0);
    send_frame(8'h81);
    chk("relock2_y", y, 8'h81);
    chk("relock2_y_valid", {7'd0, y_valid}, 8'd1);
    chk("relock2_locked", {7'd0, locked}, 8'd1);

    // gapped beats; fsync/din on idle cycles must be ignored
    for (int i = 0; i < 8; i++) begin
      beat(8'h5A >> i, (i == 0));
      if (i < 7) begin
        @(negedge clk);
        din_en = 1'b0; fsync = 1'b1; din = 1'b1;
        @(posedge clk); #1;
      end
      if (i == 6) begin
        chk("gap_early_y_valid", {7'd0, y_valid}, 8'd0);
        chk("gap_idle_sync_err", {7'd0, sync_err}, 8'd0);
      end
    end
    par(8'h5A, 1'b0);
    chk("gap_y_valid", {7'd0, y_valid}, 8'd1);
    chk("gap_y", y, 8'h5A);
    chk("gap_locked", {7'd0, locked}, 8'd1);

`ifdef TDM_DEMUX_PARITY_EN
    beats(8'hA5, 0, 7);
    par(8'hA5, 1'b1);
    chk("par_bad_err", {7'd0, parity_err}, 8'd1);
    chk("par_bad_y_valid", {7'd0, y_valid}, 8'd0);
    chk("par_bad_locked", {7'd0, locked}, 8'd1);
    chk("par_bad_y_hold", y, 8'h5A);
    send_frame(8'hA5);
    chk("par_ok_err", {7'd0, parity_err}, 8'd0);
    chk("par_ok_y", y, 8'hA5);
    chk("par_ok_y_valid", {7'd0, y_valid}, 8'd1);
`endif

    // reset on slot 5 of a locked frame
    beats(8'hC3, 0, 4);
    @(negedge clk);
    rst_n = 1'b0; din = 1'b1; fsync = 1'b0; din_en = 1'b1;
    @(posedge clk); #1;
    chk("midrst_y", y, 8'h00);
    chk("midrst_locked", {7'd0, locked}, 8'd0);
    chk("midrst_y_valid", {7'd0, y_valid}, 8'd0);
    chk("midrst_sync_err", {7'd0, sync_err}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1; din_en = 1'b0;
    beat(1'b1, 1'b0);
    chk("post_rst_hunt_err", {7'd0, sync_err}, 8'd0);
    send_frame(8'hC3);
    chk("post_rst_f1_y_valid", {7'd0, y_valid}, 8'd0);
    chk("post_rst_f1_locked", {7'd0, locked}, 8'd0);
    chk("post_rst_f1_y", y, 8'h00);
    send_frame(8'hC3);
    chk("post_rst_lock_y", y, 8'hC3);
    chk("post_rst_lock_locked", {7'd0, locked}, 8'd1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
